// File: rtl/pipe_scoreboard_pkg.sv
// pipe_sb_pkg: shared types and helpers for the pipeline hazard/forwarding
// scoreboard.
//   sb_entry_t        - one tracked in-flight writer {valid, rd, is_load}
//   FWD_SEL_REGFILE   - forwarding select value meaning "read register file"
//   fwd_sel_of_stage  - forwarding select value for a writer sitting in stage k
package pipe_sb_pkg;

  // Register address width held in an entry (RV32: x0..x31).
  localparam int SB_REG_AW = 5;

  typedef struct packed {
    logic                 valid;
    logic [SB_REG_AW-1:0] rd;
    logic                 is_load;
  } sb_entry_t;

  localparam int FWD_SEL_REGFILE = 0;

  function automatic int fwd_sel_of_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// pipe_scoreboard_if: decode-side bundle between the ID stage and the
// scoreboard.
//   master (decode) drives: stall_in, issue_valid, issue_rd, issue_is_load,
//                           src_addr, src_used, flush_mask
//   slave (scoreboard) drives: hazard_stall, fwd_sel, valid_mask, stall_cnt
interface pipe_scoreboard_if #(
  parameter int STAGES  = 3,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int SELW    = $clog2(STAGES + 1)
);

  logic                      stall_in;
  logic                      issue_valid;
  logic [REG_AW-1:0]         issue_rd;
  logic                      issue_is_load;
  logic [NUM_SRC*REG_AW-1:0] src_addr;
  logic [NUM_SRC-1:0]        src_used;
  logic [STAGES:0]           flush_mask;
  logic                      hazard_stall;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic [STAGES-1:0]         valid_mask;
  logic [15:0]               stall_cnt;

  modport master (
    output stall_in, issue_valid, issue_rd, issue_is_load,
           src_addr, src_used, flush_mask,
    input  hazard_stall, fwd_sel, valid_mask, stall_cnt
  );

  modport slave (
    input  stall_in, issue_valid, issue_rd, issue_is_load,
           src_addr, src_used, flush_mask,
    output hazard_stall, fwd_sel, valid_mask, stall_cnt
  );

endinterface

// File: rtl/pipe_scoreboard_src_match.sv
// sb_src_match: checks one decode source address against every tracked
// writer and decides whether the operand can be forwarded, must come from
// the register file, or has to stall decode.
// Ports:
//   entries  in  tracked writers, index 0 = EX (youngest)
//   src_addr in  source register address
//   src_used in  source is actually read
//   stall    out source cannot be satisfied this cycle
//   sel      out 0 = register file, k+1 = forward from stage k
// Build option: SCOREBOARD_FWD_EN enables forwarding; without it every
// match stalls until the writer has left the last tracked stage.
module sb_src_match
  import pipe_sb_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(STAGES + 1)
) (
  input  sb_entry_t [STAGES-1:0] entries,
  input  logic [REG_AW-1:0]      src_addr,
  input  logic                   src_used,
  output logic                   stall,
  output logic [SELW-1:0]        sel
);

`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic hit;
  logic hit_load;
  int   hit_k;
  logic considered;
  logic fwd_ok;

  always_comb begin
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_k    = 0;
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].rd == SB_REG_AW'(src_addr)) begin
        hit      = 1'b1;
        hit_load = entries[k].is_load;
        hit_k    = k;
      end
    end
    considered = src_used && (src_addr != '0);
    fwd_ok     = hit_k >= (hit_load ? LOAD_LAT : 0);
    stall      = considered & hit & (~FWD_EN | ~fwd_ok);
    sel        = (considered & hit & FWD_EN & fwd_ok)
               ? SELW'(fwd_sel_of_stage(hit_k))
               : SELW'(FWD_SEL_REGFILE);
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: hazard/forwarding scoreboard for the in-order pipeline.
// Tracks in-flight register writers from EX (entry 0) to WB (entry
// STAGES-1), picks a forwarding source per decode operand, or stalls decode.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high; overrides stall_in
//   sb     slave side of pipe_scoreboard_if (issue, sources, flush, freeze
//          in; hazard_stall, fwd_sel, valid_mask, stall_cnt out)
// Build option: SCOREBOARD_FWD_EN (see sb_src_match) enables forwarding.
module pipe_scoreboard
  import pipe_sb_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  pipe_scoreboard_if.slave  sb
);

  sb_entry_t [STAGES-1:0]  ent_q, ent_d;
  logic [15:0]             stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]      src_stall;
  logic [SELW-1:0]         src_sel [NUM_SRC];
  logic                    hazard;
  logic [NUM_SRC*SELW-1:0] fwd_sel_w;
  logic [STAGES-1:0]       valid_w;
  // Killing the WB entry changes nothing here: its write leaves this cycle.
  logic                    unused_flush_wb;

  assign unused_flush_wb = sb.flush_mask[STAGES];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    sb_src_match #(
      .STAGES   (STAGES),
      .REG_AW   (REG_AW),
      .LOAD_LAT (LOAD_LAT),
      .SELW     (SELW)
    ) u_match (
      .entries  (ent_q),
      .src_addr (sb.src_addr[i*REG_AW +: REG_AW]),
      .src_used (sb.src_used[i]),
      .stall    (src_stall[i]),
      .sel      (src_sel[i])
    );
  end

  assign hazard = sb.issue_valid & (|src_stall);

  always_comb begin
    ent_d       = ent_q;
    stall_cnt_d = stall_cnt_q;
    if (!sb.stall_in) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        ent_d[k] = ent_q[k-1];
        if (sb.flush_mask[k]) ent_d[k].valid = 1'b0;
      end
      // A stalled, flushed or x0-writing issue becomes a bubble in EX.
      ent_d[0].valid   = sb.issue_valid & ~hazard & ~sb.flush_mask[0]
                       & (sb.issue_rd != '0);
      ent_d[0].rd      = SB_REG_AW'(sb.issue_rd);
      ent_d[0].is_load = sb.issue_is_load;
      if (hazard && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ent_q       <= ent_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    fwd_sel_w = '0;
    for (int i = 0; i < NUM_SRC; i++) fwd_sel_w[i*SELW +: SELW] = src_sel[i];
    valid_w = '0;
    for (int k = 0; k < STAGES; k++) valid_w[k] = ent_q[k].valid;
  end

  assign sb.hazard_stall = hazard;
  assign sb.fwd_sel      = fwd_sel_w;
  assign sb.valid_mask   = valid_w;
  assign sb.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;
  import pipe_sb_pkg::*;

  localparam int S1  = 3;
  localparam int N1  = 2;
  localparam int AW  = 5;
  localparam int LL1 = 1;
  localparam int W1  = $clog2(S1 + 1);
  localparam int S2  = 8;
  localparam int N2  = 3;
  localparam int LL2 = 7;
  localparam int W2  = $clog2(S2 + 1);
`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_scoreboard_if #(.STAGES(S1), .NUM_SRC(N1), .REG_AW(AW), .SELW(W1)) sb1 ();
  pipe_scoreboard_if #(.STAGES(S2), .NUM_SRC(N2), .REG_AW(AW), .SELW(W2)) sb2 ();

  pipe_scoreboard #(.STAGES(S1), .NUM_SRC(N1), .REG_AW(AW), .LOAD_LAT(LL1), .SELW(W1))
    dut1 (.clk(clk), .reset(reset), .sb(sb1));
  pipe_scoreboard #(.STAGES(S2), .NUM_SRC(N2), .REG_AW(AW), .LOAD_LAT(LL2), .SELW(W2))
    dut2 (.clk(clk), .reset(reset), .sb(sb2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (queue of writers with age) ----------
  typedef struct { logic [4:0] rd; bit ld; int age; } wr_t;
  wr_t q[$];
  int  m_cnt;

  task automatic model_eval(input logic iv, input logic [9:0] src, input logic [1:0] used,
                            output logic haz, output logic [3:0] sel, output logic [2:0] vm);
    logic [4:0] a;
    int best;
    haz = 1'b0; sel = '0; vm = '0;
    foreach (q[j]) vm[q[j].age] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = src[i*5 +: 5];
      best = -1;
      foreach (q[j])
        if (q[j].rd == a && (best < 0 || q[j].age < q[best].age)) best = j;
      if (used[i] && a != 0 && best >= 0) begin
        if (FWD && q[best].age >= (q[best].ld ? LL1 : 0)) sel[i*2 +: 2] = 2'(q[best].age + 1);
        else if (iv) haz = 1'b1;
      end
    end
  endtask

  task automatic model_update(input logic iv, input logic [4:0] rd, input logic ld,
                              input logic [3:0] fl, input logic stl, input logic rst,
                              input logic haz);
    wr_t nq[$];
    if (rst) begin
      q.delete(); m_cnt = 0;
    end else if (!stl) begin
      foreach (q[j])
        if (!fl[q[j].age + 1] && q[j].age + 1 < S1)
          nq.push_back('{rd: q[j].rd, ld: q[j].ld, age: q[j].age + 1});
      if (iv && !haz && !fl[0] && rd != 0) nq.push_front('{rd: rd, ld: ld, age: 0});
      q = nq;
      if (haz && m_cnt < 65535) m_cnt++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive1(input logic iv, input int rd, input logic ld, input int s0, input int s1,
                        input logic [1:0] used, input logic [3:0] fl, input logic stl);
    sb1.issue_valid   = iv;
    sb1.issue_rd      = 5'(rd);
    sb1.issue_is_load = ld;
    sb1.src_addr      = {5'(s1), 5'(s0)};
    sb1.src_used      = used;
    sb1.flush_mask    = fl;
    sb1.stall_in      = stl;
  endtask

  task automatic idle2();
    sb2.issue_valid = 1'b0; sb2.issue_rd = '0; sb2.issue_is_load = 1'b0;
    sb2.src_addr = '0; sb2.src_used = '0; sb2.flush_mask = '0; sb2.stall_in = 1'b0;
  endtask

  task automatic reset_all();
    @(negedge clk);
    reset = 1'b1;
    drive1(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);
    idle2();
    q.delete(); m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic iv; logic [4:0] rd; logic ld; logic [4:0] s0, s1; logic [1:0] used;
    logic [3:0] fl; logic haz; logic [1:0] sel1, sel0; logic [2:0] vm;
  } vec_t;
  vec_t tbl[31];

  function automatic vec_t mk(input logic iv, input int rd, input logic ld, input int s0,
                              input int s1, input logic [1:0] used, input logic [3:0] fl,
                              input logic haz, input int sel1, input int sel0,
                              input logic [2:0] vm);
    vec_t v;
    v.iv = iv; v.rd = 5'(rd); v.ld = ld; v.s0 = 5'(s0); v.s1 = 5'(s1); v.used = used;
    v.fl = fl; v.haz = haz; v.sel1 = 2'(sel1); v.sel0 = 2'(sel0); v.vm = vm;
    return v;
  endfunction

  logic        e_haz;
  logic [3:0]  e_sel;
  logic [2:0]  e_vm;
  logic        r_iv, r_ld, r_stl, r_rst;
  logic [4:0]  r_rd;
  logic [9:0]  r_src;
  logic [1:0]  r_used;
  logic [3:0]  r_fl;
  int          p2;

  initial begin
    reset = 1'b1;
    drive1(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);
    idle2();

    // ALU chain, load-use, youngest priority, x0/unused, flush, flush+hazard
    tbl[0]  = mk(1, 5, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b000);
    tbl[1]  = mk(1, 6, 0, 5, 0, 2'b01, 4'b0000, !FWD, 0, FWD ? 1 : 0, 3'b001);
    tbl[2]  = mk(0, 0, 0, 5, 0, 2'b01, 4'b0000, 0, 0, FWD ? 2 : 0, FWD ? 3'b011 : 3'b010);
    tbl[3]  = mk(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, FWD ? 3'b110 : 3'b100);
    tbl[4]  = mk(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, FWD ? 3'b100 : 3'b000);
    tbl[5]  = mk(1, 7, 1, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b000);
    tbl[6]  = mk(1, 8, 0, 0, 7, 2'b10, 4'b0000, 1, 0, 0, 3'b001);
    tbl[7]  = mk(1, 8, 0, 0, 7, 2'b10, 4'b0000, !FWD, FWD ? 2 : 0, 0, 3'b010);
    tbl[8]  = mk(0, 0, 0, 0, 7, 2'b10, 4'b0000, 0, FWD ? 3 : 0, 0, FWD ? 3'b101 : 3'b100);
    tbl[9]  = mk(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, FWD ? 3'b010 : 3'b000);
    tbl[10] = mk(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, FWD ? 3'b100 : 3'b000);
    tbl[11] = mk(1, 3, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b000);
    tbl[12] = mk(1, 1, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b001);
    tbl[13] = mk(1, 3, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b011);
    tbl[14] = mk(0, 0, 0, 3, 0, 2'b01, 4'b0000, 0, 0, FWD ? 1 : 0, 3'b111);
    tbl[15] = mk(0, 0, 0, 3, 0, 2'b01, 4'b0000, 0, 0, FWD ? 2 : 0, 3'b110);
    tbl[16] = mk(0, 0, 0, 3, 0, 2'b01, 4'b0000, 0, 0, FWD ? 3 : 0, 3'b100);
    tbl[17] = mk(0, 0, 0, 3, 0, 2'b01, 4'b0000, 0, 0, 0, 3'b000);
    tbl[18] = mk(1, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b000);
    tbl[19] = mk(1, 2, 0, 0, 0, 2'b01, 4'b0000, 0, 0, 0, 3'b000);
    tbl[20] = mk(1, 4, 0, 2, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b001);
    tbl[21] = mk(1, 9, 0, 0, 0, 2'b11, 4'b0001, 0, 0, 0, 3'b011);
    tbl[22] = mk(0, 0, 0, 4, 0, 2'b01, 4'b0100, 0, 0, FWD ? 2 : 0, 3'b110);
    tbl[23] = mk(1, 4, 0, 4, 0, 2'b01, 4'b0000, 0, 0, 0, 3'b000);
    tbl[24] = mk(0, 0, 0, 4, 0, 2'b01, 4'b0010, 0, 0, FWD ? 1 : 0, 3'b001);
    tbl[25] = mk(0, 0, 0, 4, 0, 2'b01, 4'b0000, 0, 0, 0, 3'b000);
    tbl[26] = mk(1, 7, 1, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b000);
    tbl[27] = mk(1, 10, 0, 7, 0, 2'b01, 4'b0001, 1, 0, 0, 3'b001);
    tbl[28] = mk(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b010);
    tbl[29] = mk(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b100);
    tbl[30] = mk(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 3'b000);

    // Reset state
    reset_all();
    chk("rst_haz", 32'(sb1.hazard_stall), 0);
    chk("rst_sel", 32'(sb1.fwd_sel), 0);
    chk("rst_vm", 32'(sb1.valid_mask), 0);
    chk("rst_cnt", 32'(sb1.stall_cnt), 0);
    chk("rst_cnt2", 32'(sb2.stall_cnt), 0);

    // Table-driven directed sequence
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      drive1(tbl[i].iv, int'(tbl[i].rd), tbl[i].ld, int'(tbl[i].s0), int'(tbl[i].s1),
             tbl[i].used, tbl[i].fl, 1'b0);
      #1;
      chk($sformatf("tbl%0d_haz", i), 32'(sb1.hazard_stall), 32'(tbl[i].haz));
      chk($sformatf("tbl%0d_sel", i), 32'(sb1.fwd_sel), 32'({tbl[i].sel1, tbl[i].sel0}));
      chk($sformatf("tbl%0d_vm", i), 32'(sb1.valid_mask), 32'(tbl[i].vm));
    end
    @(negedge clk);
    #1;
    chk("tbl_cnt", 32'(sb1.stall_cnt), FWD ? 2 : 4);

    // Freeze: load in EX, dependent issue with flush of everything while frozen
    reset_all();
    @(negedge clk);
    drive1(1, 7, 1, 0, 0, 2'b00, 4'b0000, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive1(1, 12, 0, 7, 0, 2'b01, 4'b1111, 1);
      #1;
      chk($sformatf("frz%0d_haz", c), 32'(sb1.hazard_stall), 1);
      chk($sformatf("frz%0d_vm", c), 32'(sb1.valid_mask), 32'b001);
      chk($sformatf("frz%0d_sel", c), 32'(sb1.fwd_sel), 0);
      chk($sformatf("frz%0d_cnt", c), 32'(sb1.stall_cnt), 0);
    end
    @(negedge clk);
    drive1(1, 12, 0, 7, 0, 2'b01, 4'b0000, 0);
    #1;
    chk("thaw_vm", 32'(sb1.valid_mask), 32'b001);
    chk("thaw_haz", 32'(sb1.hazard_stall), 1);
    @(negedge clk);
    drive1(0, 0, 0, 7, 0, 2'b01, 4'b0000, 0);
    #1;
    chk("thaw_cnt", 32'(sb1.stall_cnt), 1);
    chk("thaw_vm2", 32'(sb1.valid_mask), 32'b010);
    chk("thaw_sel", 32'(sb1.fwd_sel), FWD ? 2 : 0);

    // Randomized run against the queue model, with occasional resets
    reset_all();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r_iv   = ($urandom_range(0, 3) != 0);
      r_rd   = 5'($urandom_range(0, 7));
      r_ld   = ($urandom_range(0, 2) == 0);
      r_src  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      r_used = 2'($urandom_range(0, 3));
      r_fl   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      r_stl  = ($urandom_range(0, 7) == 0);
      r_rst  = ($urandom_range(0, 299) == 0);
      drive1(r_iv, int'(r_rd), r_ld, int'(r_src[4:0]), int'(r_src[9:5]), r_used, r_fl, r_stl);
      reset = r_rst;
      #1;
      model_eval(r_iv, r_src, r_used, e_haz, e_sel, e_vm);
      chk("rnd_haz", 32'(sb1.hazard_stall), 32'(e_haz));
      chk("rnd_sel", 32'(sb1.fwd_sel), 32'(e_sel));
      chk("rnd_vm", 32'(sb1.valid_mask), 32'(e_vm));
      chk("rnd_cnt", 32'(sb1.stall_cnt), 32'(m_cnt));
      model_update(r_iv, r_rd, r_ld, r_fl, r_stl, r_rst, e_haz);
    end
    @(negedge clk);
    reset = 1'b0;

    // Saturation on the deep instance: a load and its consumer held forever
    reset_all();
    p2 = FWD ? (LL2 + 1) : (S2 + 1);
    @(negedge clk);
    sb2.issue_valid = 1'b1; sb2.issue_rd = 5'd7; sb2.issue_is_load = 1'b1;
    sb2.src_addr = {5'd0, 5'd0, 5'd7}; sb2.src_used = 3'b001;
    #1;
    chk("sat_n0_haz", 32'(sb2.hazard_stall), 0);
    for (int n = 1; n <= 76000; n++) begin
      @(negedge clk);
      #1;
      if (n < 40) begin
        chk($sformatf("sat_n%0d_haz", n), 32'(sb2.hazard_stall), 32'((n % p2) != 0));
        chk($sformatf("sat_n%0d_sel", n), 32'(sb2.fwd_sel),
            (FWD && (n % p2) == 0) ? 32'(S2) : 0);
      end
      if (n == 9000) chk("sat_mid_cnt", 32'(sb2.stall_cnt), 32'(n - (n + p2 - 1) / p2));
    end
    chk("sat_cnt", 32'(sb2.stall_cnt), 32'hFFFF);

    // Mid-operation reset beats a freeze
    @(negedge clk);
    reset = 1'b1;
    sb2.stall_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst2_cnt", 32'(sb2.stall_cnt), 0);
    chk("rst2_vm", 32'(sb2.valid_mask), 0);
    chk("rst2_haz", 32'(sb2.hazard_stall), 0);
    chk("rst2_sel", 32'(sb2.fwd_sel), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
Parametrised hazard/forwarding scoreboard for the in-order RV32 pipeline. It replaces the hard-wired ID-stage hazard and forwarding equations.
- Tracks every in-flight register writer from EX through WB in a shift-register of entries.
- For each decode source operand, selects a forwarding source (pipeline stage or register file) or requests a stall.
- Pipeline depth, source-operand count and load latency are parameters; selective flush and a stall-cycle counter are added.

Parameters:
STAGES, 3, number of tracked post-decode stages (0=EX … STAGES-1=WB), >=1
NUM_SRC, 2, source operands checked per issue (3 for fused ops)
REG_AW, 5, register address width
LOAD_LAT, 1, stage index from which load data is forwardable (< STAGES)
SELW, $clog2(STAGES+1), derived width of each forwarding select

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
stall_in  in  1  global freeze (external stop); no entry movement
issue_valid  in  1  decode presents an instruction
issue_rd  in  REG_AW  destination of issuing instruction
issue_is_load  in  1  issuing instruction's result comes from data memory
src_addr  in  NUM_SRC*REG_AW  packed source addresses, src i at [i*REG_AW +: REG_AW]
src_used  in  NUM_SRC  source i is actually read
flush_mask  in  STAGES+1  bit0 kills the issuing instruction; bit k+1 kills entry k
hazard_stall  out  1  decode must hold and a bubble enters EX
fwd_sel  out  NUM_SRC*SELW  per source: 0=register file, k+1=forward from stage k
valid_mask  out  STAGES  entry valid bits, for debug/verification
stall_cnt  out  16  saturating count of hazard-stall cycles

Behaviour:
- Entry k holds {valid, rd, is_load}.
- Entries with rd==0 are never stored valid; an x0 writer becomes a bubble.
- On each clk edge with !stall_in:
  - entry[k] <= entry[k-1] for k>=1, with valid cleared if flush_mask[k] (entry k-1 killed).
  - entry[0] <= {issue_valid & !hazard_stall & !flush_mask[0] & issue_rd!=0, issue_rd, issue_is_load}.
  - The entry leaving stage STAGES-1 is dropped (its write commits that cycle).
- stall_in=1: all entries hold, including flush effects, which are ignored that cycle. Outputs remain combinational on the current inputs.
- Per source i (combinational), the match is the youngest valid entry, i.e. lowest k, with rd==src_addr_i. It is considered only if src_used[i] and src_addr_i!=0.
  - No match: fwd_sel_i=0.
  - Match at k with k>=ready(entry): fwd_sel_i=k+1, where ready = LOAD_LAT if is_load else 0.
  - Match at k with k<ready: source stalls, fwd_sel_i=0.
- hazard_stall = issue_valid & OR over sources of the per-source stall. hazard_stall=0 when !issue_valid.
- The issuing instruction is never compared against its own rd.
- Latency:
  - An ALU writer is forwardable to the instruction issued 1 cycle later (sel=1).
  - A load writer costs LOAD_LAT stall cycles (LOAD_LAT=1: a 1-cycle load-use bubble).
- stall_cnt:
  - Increments on edges where hazard_stall & !stall_in.
  - Saturates at 16'hFFFF and never wraps.
  - Cleared only by reset.
- Reset (also valid mid-operation, takes priority over stall_in):
  - All entries invalid, stall_cnt=0.
  - Hence hazard_stall=0, fwd_sel=0, valid_mask=0 in the following cycle.
- Simultaneous flush and hazard: flush_mask[0] with hazard_stall still inserts a bubble. Flush of entry k also applies when that entry is the match target; the match uses pre-edge state.

Optional Feature:
SCOREBOARD_FWD_EN
- Defined: forwarding behaves as above.
- Undefined: no forwarding. Any match stalls until the writer has left stage STAGES-1, and fwd_sel is constant 0. Register-file write-before-read is required.

Decomposition:
- Package pipe_sb_pkg holds:
  - the sb_entry_t typedef {valid, rd, is_load}
  - constant FWD_SEL_REGFILE = 0
  - a function fwd_sel_of_stage(k) = k+1
- One sub-module, sb_src_match: one source address against all entries → {stall, sel}. It is instantiated NUM_SRC times via generate.

Test Plan:
- ALU chain: issue rd=5 (non-load); next cycle issue src0=5 used → hazard_stall=0, fwd_sel0=1; a cycle later the same source gives sel=2.
- Load-use (LOAD_LAT=1): load rd=7, then src1=7 → hazard_stall=1 for exactly 1 cycle, valid_mask bit0=0 next cycle, then fwd_sel1=2, stall_cnt=1.
- Youngest priority: writers rd=3 at stages 0 and 2 → fwd_sel=1; with writer rd=3 only at stage 2 → fwd_sel=3; after it drops → 0.
- x0 and unused: writer rd=0 → valid_mask=0; src_addr=0 or src_used=0 with a matching writer → no stall, sel=0.
- Flush: entry rd=4 at stage 0, flush_mask=3'b010 → next cycle src=4 gives sel=0. flush_mask[0] with issue rd=9 → no entry created.
- Freeze/saturation: stall_in=1 for 10 cycles → valid_mask unchanged, stall_cnt unchanged. Forced hazard for 70000 cycles → stall_cnt=16'hFFFF. Reset → all outputs 0.
